// File: rtl/alu_status_capture.sv
// Purpose : captures ALU result/status pairs in a 2-entry in-order FIFO, keeps the
//           architectural flag register, a sticky overflow bit and a condition-code evaluator.
// Latency : 1 cycle from push to head. Backpressure: inReady drops when both slots are full
//           (no same-cycle pass-through from outReady); outputs hold while outReady=0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inValid/inReady/inResult/inStatus    producer side (push = inValid && inReady)
//   outValid/outReady/outResult/outStatus consumer side (pop = outValid && outReady)
//   flags                         status of the most recent push
//   condSel/condTrue              condition selector and its evaluation against flags
//   stickyOvf/stickyClr           sticky overflow and its clear (set wins over clear)
//   count                         registered FIFO occupancy, 0..2
module alu_status_capture #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inResult,
    input  logic [3:0]       inStatus,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outResult,
    output logic [3:0]       outStatus,
    output logic [3:0]       flags,
    input  logic [3:0]       condSel,
    output logic             condTrue,
    output logic             stickyOvf,
    input  logic             stickyClr,
    output logic [1:0]       count
);

    localparam int ST_NEG      = 3;
    localparam int ST_ZERO     = 2;
    localparam int ST_CARRY    = 1;
    localparam int ST_OVERFLOW = 0;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [3:0]       status;
    } entry_t;

    entry_t     head_q;
    entry_t     tail_q;
    entry_t     in_ent;
    logic [1:0] count_q;
    logic [3:0] flags_q;
    logic       sticky_q;
    logic       push;
    logic       pop;

    assign in_ent   = '{result: inResult, status: inStatus};

    // inReady depends only on registered occupancy and rst, never on outReady.
    assign inReady  = (count_q != 2'd2) && !rst;
    assign outValid = (count_q != 2'd0);
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= 2'd0;
            flags_q  <= 4'd0;
            sticky_q <= 1'b0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= in_ent;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    // push+pop at one entry: the new pair replaces the head directly.
                    if (push && pop) begin
                        head_q <= in_ent;
                    end else if (push) begin
                        tail_q  <= in_ent;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                2'd2: begin
                    // push is impossible here because inReady is low.
                    if (pop) begin
                        head_q  <= tail_q;
                        count_q <= 2'd1;
                    end
                end
                default: count_q <= 2'd0;
            endcase

            if (push) begin
                flags_q <= inStatus;
            end

            // A new overflow outranks a clear arriving in the same cycle.
            if (push && inStatus[ST_OVERFLOW]) begin
                sticky_q <= 1'b1;
            end else if (stickyClr) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign outResult = head_q.result;
    assign outStatus = head_q.status;
    assign flags     = flags_q;
    assign stickyOvf = sticky_q;
    assign count     = count_q;

    logic f_n;
    logic f_z;
    logic f_c;
    logic f_v;

    assign f_n = flags_q[ST_NEG];
    assign f_z = flags_q[ST_ZERO];
    assign f_c = flags_q[ST_CARRY];
    assign f_v = flags_q[ST_OVERFLOW];

    always_comb begin
        condTrue = 1'b0;
        case (condSel)
            4'd0:    condTrue = f_z;
            4'd1:    condTrue = !f_z;
            4'd2:    condTrue = f_n;
            4'd3:    condTrue = !f_n;
            4'd4:    condTrue = f_c;
            4'd5:    condTrue = !f_c;
            4'd6:    condTrue = f_v;
            4'd7:    condTrue = !f_v;
            4'd8:    condTrue = !f_z && (f_n == f_v);
            4'd9:    condTrue = (f_n == f_v);
            4'd10:   condTrue = (f_n != f_v);
            4'd11:   condTrue = f_z || (f_n != f_v);
            4'd12:   condTrue = f_c && !f_z;
            4'd13:   condTrue = !f_c || f_z;
            4'd14:   condTrue = 1'b1;
            default: condTrue = 1'b0;
        endcase
    end

endmodule

// File: doc/alu_status_capture.md
ALU_STATUS_CAPTURE -- requirements
Module: alu_status_capture

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the ALU result width.
REQ-002 The block SHALL use status bit positions ST_NEG=3, ST_ZERO=2, ST_CARRY=1, ST_OVERFLOW=0 on every 4-bit status bus.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 inValid  input  1  producer presents an ALU result/status pair.
REQ-006 inReady  output  1  block can accept the pair this cycle.
REQ-007 inResult  input  WIDTH  ALU result.
REQ-008 inStatus  input  4  ALU status flags.
REQ-009 outValid  output  1  head entry available.
REQ-010 outReady  input  1  consumer takes the head entry.
REQ-011 outResult  output  WIDTH  head entry result.
REQ-012 outStatus  output  4  head entry status.
REQ-013 flags  output  4  architectural flag register.
REQ-014 condSel  input  4  condition code selector.
REQ-015 condTrue  output  1  selected condition evaluated against flags.
REQ-016 stickyOvf  output  1  sticky overflow indicator.
REQ-017 stickyClr  input  1  clears stickyOvf.
REQ-018 count  output  2  FIFO occupancy, 0..2.

Function
REQ-019 The block SHALL buffer pairs in a 2-entry in-order FIFO; push = inValid && inReady, pop = outValid && outReady.
REQ-020 inReady SHALL equal (count != 2) && !rst, with no combinational path from outReady (no pass-through when full).
REQ-021 outValid SHALL equal (count != 0); outResult/outStatus SHALL come from registered storage, never directly from inResult/inStatus.
REQ-022 Push into an empty FIFO SHALL give outValid=1 with that data in the next cycle, for a latency of 1 cycle.
REQ-023 Simultaneous push and pop at count=1 SHALL leave count=1, with the pushed entry becoming head next cycle.
REQ-024 Pop at count=2 SHALL promote the second entry to head next cycle.
REQ-025 Pop SHALL be ignored when count=0, and push SHALL be ignored when count=2; no state change and no underflow or overflow of count.
REQ-026 outResult/outStatus SHALL hold stable while outValid=1 && outReady=0.
REQ-027 flags SHALL load inStatus on every push cycle (next edge) and otherwise hold, independent of pops.
REQ-028 condTrue SHALL be combinational from flags and condSel, with N,Z,C,V taken from flags: 0 EQ Z; 1 NE !Z; 2 MI N; 3 PL !N; 4 CS C; 5 CC !C; 6 VS V; 7 VC !V; 8 GT !Z&&(N==V); 9 GE N==V; 10 LT N!=V; 11 LE Z||(N!=V); 12 HI C&&!Z; 13 LS !C||Z; 14 AL 1; 15 NV 0.
REQ-029 stickyOvf SHALL set on a push with inStatus[ST_OVERFLOW]=1 and clear on stickyClr=1; if both occur in the same cycle, set SHALL win.
REQ-030 count SHALL reflect registered occupancy, and SHALL be updated once per edge for the net of push and pop.

Reset
REQ-031 With rst=1 at an edge, count, flags, stickyOvf, FIFO storage and outValid SHALL be 0 after that edge.
REQ-032 inReady SHALL be 0 while rst=1; inputs presented during reset SHALL be discarded.
REQ-033 Reset mid-operation (count=2) SHALL drop both entries; the first cycle after rst deasserts SHALL show count=0, inReady=1.

Verification
REQ-034 Single push: push result=0x00FF, status=0b0100 into an empty FIFO, outReady=0 -> next cycle outValid=1, outResult=0x00FF, flags=0b0100, condSel=0 gives condTrue=1.
REQ-035 Fill and backpressure: push A=0x1111, then B=0x2222, with outReady=0 -> count=2, inReady=0; a third push of 0x3333 is dropped; then outReady=1 for 2 cycles -> 0x1111 then 0x2222, then outValid=0.
REQ-036 Simultaneous push/pop at count=1: head=0x0001, push 0x0002 with outReady=1 -> count stays 1, next head=0x0002.
REQ-037 Sticky overflow: push status=0b0001 while stickyClr=1 in the same cycle -> stickyOvf=1; next cycle stickyClr=1 with no push -> stickyOvf=0.
REQ-038 Condition sweep: flags=0b1000 (N=1, V=0) -> LT=1, GE=0, GT=0, LE=1, MI=1, AL=1, NV=0; flags=0b0010 (C=1) -> HI=1, LS=0.
REQ-039 Reset mid-stream: at count=2, pulse rst for 1 cycle -> count=0, outValid=0, flags=0, stickyOvf=0, and inReady=1 the cycle after.
